// File: rtl/pi_loop_scheduler.sv
// pi_loop_scheduler: periodic tick, sign-magnitude error, PI handshake under watchdog, clamped actuator command
module pi_loop_scheduler #(
    parameter int WIDTH   = 16,
    parameter int FBITS   = 7,
    parameter int PERIOD  = 50000,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             nReset_i,
    input  logic             run_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] setpoint_i,
    input  logic [WIDTH-1:0] feedback_i,
    input  logic [WIDTH-2:0] out_lim_i,
    output logic             pi_enable_o,
    output logic [WIDTH-1:0] pi_delta_o,
    input  logic [WIDTH-1:0] pi_i,
    input  logic             pi_finish_i,
    output logic [WIDTH-1:0] ctrl_o,
    output logic             ctrl_valid_o,
    output logic             busy_o,
    output logic             overrun_o,
    output logic             timeout_o
);
    localparam int CW = $clog2(PERIOD);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] IDLE = 3'd0, SAMPLE = 3'd1, FIRE = 3'd2, WAIT = 3'd3, LIMIT = 3'd4;

    if (FBITS >= WIDTH || PERIOD < 8 || TIMEOUT < 2) begin : g_bad_params
        $error("pi_loop_scheduler: illegal parameter combination");
    end

    logic [2:0]              state, next;
    logic [CW-1:0]           cnt;
    logic [WW-1:0]           wd;
    logic                    fin_q;
    logic [WIDTH-1:0]        pi_q;
    logic                    tick, fin_edge, wd_exp;
    logic signed [WIDTH:0]   sp_tc, fb_tc, diff;
    logic [WIDTH:0]          diff_mag;
    logic [WIDTH-2:0]        d_mag, c_mag;
    logic [WIDTH-1:0]        delta, clamped;

    always_comb begin
        tick     = run_i && cnt == CW'(PERIOD - 1);
        fin_edge = pi_finish_i && !fin_q;
        wd_exp   = wd == WW'(TIMEOUT - 1);
        // -0 maps to 0 naturally because the negated magnitude is zero
        sp_tc    = setpoint_i[WIDTH-1] ? -$signed({2'b00, setpoint_i[WIDTH-2:0]}) : $signed({2'b00, setpoint_i[WIDTH-2:0]});
        fb_tc    = feedback_i[WIDTH-1] ? -$signed({2'b00, feedback_i[WIDTH-2:0]}) : $signed({2'b00, feedback_i[WIDTH-2:0]});
        diff     = sp_tc - fb_tc;
        diff_mag = $unsigned(diff[WIDTH] ? -diff : diff);
        d_mag    = |diff_mag[WIDTH:WIDTH-1] ? '1 : diff_mag[WIDTH-2:0];
        delta    = {diff[WIDTH] && d_mag != '0, d_mag};
        c_mag    = pi_q[WIDTH-2:0] > out_lim_i ? out_lim_i : pi_q[WIDTH-2:0];
        clamped  = {pi_q[WIDTH-1] && c_mag != '0, c_mag};
        next     = state == IDLE   ? (tick ? SAMPLE : IDLE) :
                   state == SAMPLE ? FIRE :
                   state == FIRE   ? WAIT :
                   state == WAIT   ? (fin_edge ? LIMIT : wd_exp ? IDLE : WAIT) : IDLE;
    end

    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            state        <= IDLE;
            cnt          <= '0;
            wd           <= '0;
            fin_q        <= 1'b0;
            pi_q         <= '0;
            pi_enable_o  <= 1'b0;
            pi_delta_o   <= '0;
            ctrl_o       <= '0;
            ctrl_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            overrun_o    <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state        <= next;
            cnt          <= (tick || !run_i) ? '0 : cnt + 1'b1;
            fin_q        <= pi_finish_i;
            pi_enable_o  <= state == SAMPLE;
            ctrl_valid_o <= state == LIMIT;
            // busy follows the registered outputs: on from T+1, off once the strobe/timeout cycle is past
            busy_o       <= tick || state != IDLE;
            overrun_o    <= (tick && state != IDLE) || (overrun_o && !clear_i);
            timeout_o    <= (state == WAIT && !fin_edge && wd_exp) || (timeout_o && !clear_i);
            if (state == SAMPLE) pi_delta_o <= delta;
            if (state == FIRE) wd <= '0;
            else if (state == WAIT) wd <= wd + 1'b1;
            if (state == WAIT && fin_edge) pi_q <= pi_i;
            if (state == LIMIT) ctrl_o <= clamped;
        end
    end
endmodule

// File: tb/tb_pi_loop_scheduler.sv
// tb_pi_loop_scheduler: directed checks of tick timing, error arithmetic, clamp, watchdog, overrun, run/reset
module tb_pi_loop_scheduler;
    logic        clk_i = 1'b0;
    logic        nReset_i = 1'b0;
    logic        run_a = 1'b0, run_b = 1'b0, clear_i = 1'b0;
    logic [15:0] sp = '0, fb = '0;
    logic [14:0] lim = 15'h7FFF;

    logic        en_a, val_a, busy_a, ovr_a, to_a;
    logic [15:0] delta_a, ctrl_a, pi_a;
    logic        en_b, val_b, busy_b, ovr_b, to_b;
    logic [15:0] delta_b, ctrl_b, pi_b;

    int          lat_a = 5, lat_b = 20;
    logic        never_a = 1'b0, force_a = 1'b0;
    logic [15:0] fval_a = '0;
    int          cnt_a, cnt_b;
    logic        fin_a, fin_b;
    logic [15:0] d_a, d_b;

    int vecs = 0, errs = 0;
    int n;
    logic seen;

    always #10 clk_i = ~clk_i;

    pi_loop_scheduler #(.WIDTH(16), .FBITS(7), .PERIOD(16), .TIMEOUT(8)) u_a (
        .clk_i(clk_i), .nReset_i(nReset_i), .run_i(run_a), .clear_i(clear_i),
        .setpoint_i(sp), .feedback_i(fb), .out_lim_i(lim),
        .pi_enable_o(en_a), .pi_delta_o(delta_a), .pi_i(pi_a), .pi_finish_i(fin_a),
        .ctrl_o(ctrl_a), .ctrl_valid_o(val_a), .busy_o(busy_a), .overrun_o(ovr_a), .timeout_o(to_a)
    );

    pi_loop_scheduler #(.WIDTH(16), .FBITS(7), .PERIOD(16), .TIMEOUT(32)) u_b (
        .clk_i(clk_i), .nReset_i(nReset_i), .run_i(run_b), .clear_i(clear_i),
        .setpoint_i(sp), .feedback_i(fb), .out_lim_i(lim),
        .pi_enable_o(en_b), .pi_delta_o(delta_b), .pi_i(pi_b), .pi_finish_i(fin_b),
        .ctrl_o(ctrl_b), .ctrl_valid_o(val_b), .busy_o(busy_b), .overrun_o(ovr_b), .timeout_o(to_b)
    );

    // behavioural PI blocks: finish rises lat cycles after the enable cycle
    always @(posedge clk_i or negedge nReset_i)
        if (!nReset_i) begin cnt_a <= 0; fin_a <= 1'b0; d_a <= '0; end
        else if (en_a) begin cnt_a <= lat_a - 1; fin_a <= 1'b0; d_a <= delta_a; end
        else if (cnt_a > 0) begin cnt_a <= cnt_a - 1; if (cnt_a == 1 && !never_a) fin_a <= 1'b1; end
    assign pi_a = force_a ? fval_a : d_a;

    always @(posedge clk_i or negedge nReset_i)
        if (!nReset_i) begin cnt_b <= 0; fin_b <= 1'b0; d_b <= '0; end
        else if (en_b) begin cnt_b <= lat_b - 1; fin_b <= 1'b0; d_b <= delta_b; end
        else if (cnt_b > 0) begin cnt_b <= cnt_b - 1; if (cnt_b == 1) fin_b <= 1'b1; end
    assign pi_b = d_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 en_a, 1 val_a, 2 busy_a, 3 en_b, 4 val_b, 5 ovr_b; n = negedges taken, -1 if bound expired
    task automatic wait_for(input int sel, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk_i);
            if ((sel == 0 && en_a) || (sel == 1 && val_a) || (sel == 2 && busy_a) ||
                (sel == 3 && en_b) || (sel == 4 && val_b) || (sel == 5 && ovr_b)) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic run_case(input string tag, input logic [15:0] s, input logic [15:0] f, input logic [14:0] l,
                            input logic frc, input logic [15:0] fv, input logic [15:0] exp_d, input logic [15:0] exp_c);
        int c;
        sp = s; fb = f; lim = l; force_a = frc; fval_a = fv;
        wait_for(0, c);
        chk({tag, "_en"}, 32'(c > 0), 32'd1);
        chk({tag, "_delta"}, 32'(delta_a), 32'(exp_d));
        wait_for(1, c);
        chk({tag, "_lat"}, c, 7);
        chk({tag, "_ctrl"}, 32'(ctrl_a), 32'(exp_c));
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_ctrl", 32'(ctrl_a), 0);
        chk("rst_valid", 32'(val_a), 0);
        chk("rst_en", 32'(en_a), 0);
        chk("rst_delta", 32'(delta_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_flags", {30'd0, ovr_a, to_a}, 0);
        nReset_i = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("idle_busy", 32'(busy_a), 0);

        // nominal: first tick PERIOD-1 cycles after run, busy at T+1, enable at T+2
        sp = 16'h0100; fb = 16'h0080; lim = 15'h7FFF; run_a = 1'b1;
        wait_for(2, n);
        chk("nom_busy_rise", n, 16);
        wait_for(0, n);
        chk("nom_en_lat", n, 1);
        chk("nom_delta", 32'(delta_a), 32'h0080);
        wait_for(1, n);
        chk("nom_valid_lat", n, 7);
        chk("nom_ctrl", 32'(ctrl_a), 32'h0080);
        chk("nom_busy_f2", 32'(busy_a), 1);
        @(negedge clk_i);
        chk("nom_valid_pulse", 32'(val_a), 0);
        chk("nom_busy_f3", 32'(busy_a), 0);
        wait_for(0, n);
        chk("nom_period", n, 8);
        wait_for(1, n);
        chk("nom_valid2", n, 7);

        run_case("neg", 16'h0000, 16'h0080, 15'h7FFF, 1'b0, 16'h0, 16'h8080, 16'h8080);
        run_case("sat", 16'h7FFF, 16'hFFFF, 15'h7FFF, 1'b0, 16'h0, 16'h7FFF, 16'h7FFF);
        run_case("negzero", 16'h8000, 16'h0000, 15'h7FFF, 1'b0, 16'h0, 16'h0000, 16'h0000);
        run_case("negsum", 16'h8005, 16'h0003, 15'h7FFF, 1'b0, 16'h0, 16'h8008, 16'h8008);
        run_case("clamp_neg", 16'h0100, 16'h0080, 15'h0400, 1'b1, 16'h8500, 16'h0080, 16'h8400);
        run_case("clamp_pass", 16'h0100, 16'h0080, 15'h0400, 1'b1, 16'h0300, 16'h0080, 16'h0300);
        run_case("clamp_eq", 16'h0100, 16'h0080, 15'h0400, 1'b1, 16'h0400, 16'h0080, 16'h0400);
        run_case("clamp_zero", 16'h0100, 16'h0080, 15'h0000, 1'b1, 16'h8300, 16'h0080, 16'h0000);

        // timeout: enable at E=T+2, flag visible at T+11=E+9, no strobe, ctrl held
        lim = 15'h0400; force_a = 1'b0; never_a = 1'b1;
        wait_for(0, n);
        seen = 1'b0;
        repeat (8) begin @(negedge clk_i); seen |= val_a; end
        chk("to_early", 32'(to_a), 0);
        @(negedge clk_i); seen |= val_a;
        chk("to_set", 32'(to_a), 1);
        chk("to_no_strobe", 32'(seen), 0);
        chk("to_ctrl_held", 32'(ctrl_a), 32'h0000);
        never_a = 1'b0; lim = 15'h7FFF;
        wait_for(0, n);
        chk("to_next_tick", n, 7);
        wait_for(1, n);
        chk("to_next_lat", n, 7);
        chk("to_next_ctrl", 32'(ctrl_a), 32'h0080);
        chk("to_sticky", 32'(to_a), 1);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("to_clear", 32'(to_a), 0);
        chk("a_no_overrun", 32'(ovr_a), 0);

        // run dropped in WAIT: in-flight result published, then no more enables
        sp = 16'h0040; fb = 16'h0000;
        wait_for(0, n);
        @(negedge clk_i);
        run_a = 1'b0;
        wait_for(1, n);
        chk("stop_lat", n, 6);
        chk("stop_ctrl", 32'(ctrl_a), 32'h0040);
        seen = 1'b0;
        repeat (40) begin @(negedge clk_i); seen |= en_a; end
        chk("stop_no_en", 32'(seen), 0);
        chk("stop_ctrl_kept", 32'(ctrl_a), 32'h0040);

        // asynchronous reset in WAIT
        run_a = 1'b1;
        wait_for(0, n);
        chk("rr_first_tick", n, 17);
        repeat (2) @(negedge clk_i);
        chk("rr_busy_pre", 32'(busy_a), 1);
        nReset_i = 1'b0;
        #1;
        chk("ar_ctrl", 32'(ctrl_a), 0);
        chk("ar_busy", 32'(busy_a), 0);
        chk("ar_delta", 32'(delta_a), 0);
        chk("ar_strobes", {30'd0, en_a, val_a}, 0);
        @(negedge clk_i);
        nReset_i = 1'b1;
        wait_for(0, n);
        chk("ar_restart", n, 17);
        wait_for(1, n);
        chk("ar_resume_lat", n, 7);
        chk("ar_resume_ctrl", 32'(ctrl_a), 32'h0040);
        run_a = 1'b0;

        // overrun: latency 20 on PERIOD 16, tick at T+16 dropped
        run_b = 1'b1;
        wait_for(3, n);
        chk("ov_first", n, 17);
        repeat (14) @(negedge clk_i);
        chk("ov_before", 32'(ovr_b), 0);
        @(negedge clk_i);
        chk("ov_set", 32'(ovr_b), 1);
        wait_for(4, n);
        chk("ov_valid_lat", n, 7);
        chk("ov_ctrl", 32'(ctrl_b), 32'h0040);
        wait_for(3, n);
        chk("ov_dropped", n, 10);
        run_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
